branch_resolve_unit: RTL and testbench

Execute-stage producer of the fetch-stage branch update/redirect interface. It takes each resolved control-flow instruction together with the prediction metadata that fetch attached to it. It compares actual outcome against prediction, then drives the BPU training pulse and the fetch redirect/flush controls. It also squashes the wrong-path instructions already in flight and keeps branch and mispredict performance counters.

---
 rtl/branch_resolve_unit_pkg.sv | 23 ++
 rtl/bru_squash_ctr.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 131 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and defaults for the execute-stage branch resolution slice.
// The fetch metadata bundle is shared by the fetch, decode and execute pipeline registers.
package branch_resolve_unit_pkg;

    localparam int GHR_W_DEFAULT         = 4;
    localparam int SQUASH_CYCLES_DEFAULT = 2;
    localparam int CNT_W_DEFAULT         = 32;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              predicted_pc;
        logic                     prediction_valid;
        logic [GHR_W_DEFAULT-1:0] ghr;
    } fetch_meta_t;

    // Fall-through address; wraps modulo 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/bru_squash_ctr.sv
// Wrong-path squash window: loads on a mispredict, counts down on unstalled cycles,
// holds while the execute stage is stalled.
module bru_squash_ctr
    import branch_resolve_unit_pkg::*;
#(
    parameter int SQUASH_CYCLES = SQUASH_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic stall,
    output logic active
);

    localparam int CW = $clog2(SQUASH_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    // A load only happens when the count is already zero, so load and decrement never collide.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(SQUASH_CYCLES);
        end else if ((cnt_q != '0) && !stall) begin
            cnt_d = cnt_q - CW'(1);
        end
        active_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves control-flow instructions in execute, trains the BPU, redirects or flushes fetch,
// squashes wrong-path slots and keeps branch/mispredict performance counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int GHR_W         = GHR_W_DEFAULT,
    parameter int SQUASH_CYCLES = SQUASH_CYCLES_DEFAULT,
    parameter int CNT_W         = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             ex_cond_true,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic [31:0]      ex_predicted_pc,
    input  logic             ex_prediction_valid,
    input  logic [GHR_W-1:0] ex_ghr,
    output logic [31:0]      branchAddress,
    output logic             branch_taken,
    output logic             branch_resolved,
    output logic [GHR_W-1:0] ghr_history,
    output logic [31:0]      resolved_pc,
    output logic             pc_redirect,
    output logic             flush_fetch,
    output logic             squash_active,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);

    // GHR_W is expected to equal the package width shared with fetch.
    fetch_meta_t ex_meta;
    assign ex_meta = '{pc: ex_pc, predicted_pc: ex_predicted_pc,
                       prediction_valid: ex_prediction_valid, ghr: ex_ghr};

    logic        accept, taken, mispredict;
    logic [31:0] fall_pc, exp_pc, act_pc;

    always_comb begin
        accept     = ex_valid && !ex_stall && (ex_is_branch || ex_is_jump) && !squash_active;
        taken      = ex_is_jump || (ex_is_branch && ex_cond_true);
        fall_pc    = next_seq_pc(ex_meta.pc);
        exp_pc     = ex_meta.prediction_valid ? ex_meta.predicted_pc : fall_pc;
        act_pc     = taken ? ex_target : fall_pc;
        mispredict = (exp_pc != act_pc);
    end

    bru_squash_ctr #(.SQUASH_CYCLES(SQUASH_CYCLES)) u_squash (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && mispredict),
        .stall  (ex_stall),
        .active (squash_active)
    );

    logic [31:0]      branch_address_q, branch_address_d;
    logic             branch_taken_q, branch_taken_d;
    logic             branch_resolved_q, branch_resolved_d;
    logic [GHR_W-1:0] ghr_history_q, ghr_history_d;
    logic [31:0]      resolved_pc_q, resolved_pc_d;
    logic             pc_redirect_q, pc_redirect_d;
    logic             flush_fetch_q, flush_fetch_d;
    logic [CNT_W-1:0] perf_branches_q, perf_branches_d;
    logic [CNT_W-1:0] perf_mispredicts_q, perf_mispredicts_d;

    // Strobes last one cycle; data outputs hold until the next accepted instruction.
    always_comb begin
        branch_address_d   = branch_address_q;
        branch_taken_d     = branch_taken_q;
        ghr_history_d      = ghr_history_q;
        resolved_pc_d      = resolved_pc_q;
        branch_resolved_d  = 1'b0;
        pc_redirect_d      = 1'b0;
        flush_fetch_d      = 1'b0;
        perf_branches_d    = perf_branches_q;
        perf_mispredicts_d = perf_mispredicts_q;
        if (accept) begin
            branch_address_d  = ex_target;
            branch_taken_d    = taken;
            ghr_history_d     = ex_meta.ghr;
            resolved_pc_d     = ex_meta.pc;
            branch_resolved_d = 1'b1;
            pc_redirect_d     = mispredict && taken;
            flush_fetch_d     = mispredict && !taken;
            if (perf_branches_q != '1) begin
                perf_branches_d = perf_branches_q + CNT_W'(1);
            end
            if (mispredict && (perf_mispredicts_q != '1)) begin
                perf_mispredicts_d = perf_mispredicts_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_address_q   <= '0;
            branch_taken_q     <= 1'b0;
            branch_resolved_q  <= 1'b0;
            ghr_history_q      <= '0;
            resolved_pc_q      <= '0;
            pc_redirect_q      <= 1'b0;
            flush_fetch_q      <= 1'b0;
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            branch_address_q   <= branch_address_d;
            branch_taken_q     <= branch_taken_d;
            branch_resolved_q  <= branch_resolved_d;
            ghr_history_q      <= ghr_history_d;
            resolved_pc_q      <= resolved_pc_d;
            pc_redirect_q      <= pc_redirect_d;
            flush_fetch_q      <= flush_fetch_d;
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign branchAddress    = branch_address_q;
    assign branch_taken     = branch_taken_q;
    assign branch_resolved  = branch_resolved_q;
    assign ghr_history      = ghr_history_q;
    assign resolved_pc      = resolved_pc_q;
    assign pc_redirect      = pc_redirect_q;
    assign flush_fetch      = flush_fetch_q;
    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios then random traffic, with a
// second instance using 2-bit counters to reach perf counter saturation quickly.
module tb_branch_resolve_unit;

    localparam int GHR_W  = 4;
    localparam int SQUASH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             ex_valid = 1'b0, ex_stall = 1'b0;
    logic             ex_is_branch = 1'b0, ex_is_jump = 1'b0, ex_cond_true = 1'b0;
    logic [31:0]      ex_pc = '0, ex_target = '0, ex_predicted_pc = '0;
    logic             ex_prediction_valid = 1'b0;
    logic [GHR_W-1:0] ex_ghr = '0;

    logic [31:0]      branchAddress, resolved_pc;
    logic             branch_taken, branch_resolved, pc_redirect, flush_fetch, squash_active;
    logic [GHR_W-1:0] ghr_history;
    logic [31:0]      perf_branches, perf_mispredicts;

    logic [31:0]      s_addr, s_pc;
    logic             s_taken, s_resolved, s_redirect, s_flush, s_squash;
    logic [GHR_W-1:0] s_ghr;
    logic [1:0]       s_perf_br, s_perf_mp;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_cond_true(ex_cond_true),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_predicted_pc(ex_predicted_pc),
        .ex_prediction_valid(ex_prediction_valid), .ex_ghr(ex_ghr),
        .branchAddress(branchAddress), .branch_taken(branch_taken),
        .branch_resolved(branch_resolved), .ghr_history(ghr_history),
        .resolved_pc(resolved_pc), .pc_redirect(pc_redirect), .flush_fetch(flush_fetch),
        .squash_active(squash_active), .perf_branches(perf_branches),
        .perf_mispredicts(perf_mispredicts)
    );

    branch_resolve_unit #(.CNT_W(2)) sat_dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_cond_true(ex_cond_true),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_predicted_pc(ex_predicted_pc),
        .ex_prediction_valid(ex_prediction_valid), .ex_ghr(ex_ghr),
        .branchAddress(s_addr), .branch_taken(s_taken),
        .branch_resolved(s_resolved), .ghr_history(s_ghr),
        .resolved_pc(s_pc), .pc_redirect(s_redirect), .flush_fetch(s_flush),
        .squash_active(s_squash), .perf_branches(s_perf_br),
        .perf_mispredicts(s_perf_mp)
    );

    typedef struct {
        int               cyc;
        logic [31:0]      addr;
        logic             taken;
        logic [31:0]      pc;
        logic [GHR_W-1:0] ghr;
        logic             redirect;
        logic             flush;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: remaining wrong-path slots and event counts since reset.
    int      squash_left = 0;
    longint  n_br = 0, n_mp = 0;
    bit      in_reset = 1'b1;
    bit      done = 1'b0;

    int compared = 0, mismatched = 0;

    function automatic longint sat(input longint n, input longint max);
        return (n > max) ? max : n;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic apply_stimulus(input bit r, input bit v, input bit s, input bit br, input bit j,
                                  input bit c, input logic [31:0] pc, input logic [31:0] tgt,
                                  input logic [31:0] pred, input bit pv, input logic [GHR_W-1:0] g);
        bit          acc, tk, mp;
        logic [31:0] fall, exp_pc, act_pc;
        exp_t        e;
        @(negedge clk);
        rst = r; ex_valid = v; ex_stall = s; ex_is_branch = br; ex_is_jump = j;
        ex_cond_true = c; ex_pc = pc; ex_target = tgt; ex_predicted_pc = pred;
        ex_prediction_valid = pv; ex_ghr = g;
        @(posedge clk);
        if (r) begin
            squash_left = 0; n_br = 0; n_mp = 0; in_reset = 1'b1;
        end else begin
            in_reset = 1'b0;
            acc = v && !s && (br || j) && (squash_left == 0);
            if (squash_left > 0 && !s) squash_left--;
            if (acc) begin
                tk     = j || (br && c);
                fall   = pc + 32'd4;
                exp_pc = pv ? pred : fall;
                act_pc = tk ? tgt : fall;
                mp     = (exp_pc != act_pc);
                e = '{cyc: cyc + 1, addr: tgt, taken: tk, pc: pc, ghr: g,
                      redirect: mp && tk, flush: mp && !tk};
                sb.push_back(e);
                n_br++;
                if (mp) begin
                    n_mp++;
                    squash_left = SQUASH;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, '0);
    endtask

    // Monitor: per-cycle status checks plus scoreboard matching on each resolve strobe.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!done) begin
                check_output("squash_active", {31'b0, squash_active}, {31'b0, squash_left != 0});
                check_output("perf_branches", perf_branches, 32'(sat(n_br, 64'hFFFF_FFFF)));
                check_output("perf_mispredicts", perf_mispredicts, 32'(sat(n_mp, 64'hFFFF_FFFF)));
                check_output("sat_perf_branches", {30'b0, s_perf_br}, 32'(sat(n_br, 3)));
                check_output("sat_perf_mispredicts", {30'b0, s_perf_mp}, 32'(sat(n_mp, 3)));
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    void'(sb.pop_front());
                    fail_event("missing branch_resolved");
                end
                if (branch_resolved) begin
                    if (sb.size() == 0 || sb[0].cyc != cyc) begin
                        fail_event("unexpected branch_resolved");
                    end else begin
                        e = sb.pop_front();
                        check_output("branch_taken", {31'b0, branch_taken}, {31'b0, e.taken});
                        check_output("branchAddress", branchAddress, e.addr);
                        check_output("resolved_pc", resolved_pc, e.pc);
                        check_output("ghr_history", {28'b0, ghr_history}, {28'b0, e.ghr});
                        check_output("pc_redirect", {31'b0, pc_redirect}, {31'b0, e.redirect});
                        check_output("flush_fetch", {31'b0, flush_fetch}, {31'b0, e.flush});
                    end
                end else begin
                    if (sb.size() > 0 && sb[0].cyc == cyc) begin
                        void'(sb.pop_front());
                        fail_event("missing branch_resolved");
                    end
                    check_output("idle_strobes", {30'b0, pc_redirect, flush_fetch}, 32'h0);
                end
                if (in_reset) begin
                    check_output("reset_branchAddress", branchAddress, 32'h0);
                    check_output("reset_resolved_pc", resolved_pc, 32'h0);
                    check_output("reset_taken_ghr", {27'b0, branch_taken, ghr_history}, 32'h0);
                end
            end
        end
    end

    initial begin
        logic [31:0] pc, tgt, pred, fall;
        bit          br, j, c, pv, tk;
        int          kind;

        $display("[TB] start");
        apply_stimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, '0);
        apply_stimulus(1, 1, 0, 1, 0, 1, 32'h40, 32'h80, 32'h0, 0, 4'hF);

        // Correct predict-taken.
        apply_stimulus(0, 1, 0, 1, 0, 1, 32'h100, 32'h140, 32'h140, 1, 4'b0101);
        idle(1);
        // BTB miss on a JAL, then two younger branches that must be squashed.
        apply_stimulus(0, 1, 0, 0, 1, 0, 32'h200, 32'h80, 32'h0, 0, 4'b0011);
        apply_stimulus(0, 1, 0, 1, 0, 1, 32'h84, 32'h400, 32'h400, 1, 4'b0001);
        apply_stimulus(0, 1, 0, 1, 0, 1, 32'h88, 32'h500, 32'h0, 0, 4'b0010);
        idle(1);
        // Predicted taken, actually not taken.
        apply_stimulus(0, 1, 0, 1, 0, 0, 32'h300, 32'h3A0, 32'h3A0, 1, 4'b1011);
        idle(2);
        // Stalls during the squash window hold the counter.
        apply_stimulus(0, 1, 0, 1, 0, 1, 32'h600, 32'h700, 32'h0, 0, 4'b0110);
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 1, 1, 1, 0, 1, 32'h604, 32'h800, 32'h0, 0, 4'b0111);
        idle(2);
        apply_stimulus(0, 1, 1, 1, 0, 1, 32'h610, 32'h900, 32'h900, 1, 4'b1000);
        apply_stimulus(0, 1, 0, 1, 0, 1, 32'h610, 32'h900, 32'h900, 1, 4'b1000);
        // Fall-through wraps to zero; matches a prediction of 0.
        apply_stimulus(0, 1, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h10, 32'h0, 1, 4'b1100);
        idle(1);
        // Reset in the middle of a squash window.
        apply_stimulus(0, 1, 0, 0, 1, 0, 32'hA00, 32'hB00, 32'h0, 0, 4'b1110);
        apply_stimulus(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, '0);
        idle(1);
        apply_stimulus(0, 1, 0, 1, 0, 1, 32'hC00, 32'hC40, 32'hC40, 1, 4'b1001);

        for (int n = 0; n < 800; n++) begin
            kind = int'($urandom_range(0, 3));
            br   = (kind == 1) || (kind == 3);
            j    = (kind == 2) || (kind == 3);
            c    = 1'($urandom_range(0, 1));
            pv   = 1'($urandom_range(0, 1));
            pc   = $urandom() & 32'hFFFF_FFFC;
            tgt  = $urandom() & 32'hFFFF_FFFC;
            tk   = j || (br && c);
            fall = pc + 32'd4;
            pred = ($urandom_range(0, 2) != 0) ? (tk ? tgt : fall) : ($urandom() & 32'hFFFF_FFFC);
            apply_stimulus($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0,
                           $urandom_range(0, 4) == 0, br, j, c, pc, tgt, pred, pv,
                           4'($urandom_range(0, 15)));
        end
        idle(3);
        done = 1'b1;
        check_output("scoreboard_empty", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
